// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM user-port arbiter.
// Provides the FSM state enum, default bus widths and the watchdog width helper.
package sdram_arb_pkg;

    localparam int ADR_W_DEF = 20;
    localparam int DAT_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_DATA,
        RD_REQ,
        RD_DATA,
        DONE
    } state_t;

    // Counter width able to hold 0..timeout_cyc.
    function automatic int wd_width(input int timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/sdram_port_arb_if.sv
// Requester and controller-side signals of the SDRAM user-port arbiter.
// master: arbiter view; slave: requesters plus controller view.
interface sdram_port_arb_if #(
    parameter int ADR_W = 20,
    parameter int DAT_W = 16
);
    logic             cap_req;
    logic [ADR_W-1:0] cap_adr;
    logic [DAT_W-1:0] cap_da;
    logic             cap_done;
    logic             rd_req;
    logic [ADR_W-1:0] rd_adr;
    logic             rd_done;
    logic [DAT_W-1:0] rd_da;
    logic             u_wreq;
    logic             u_rreq;
    logic             u_wack;
    logic             u_rack;
    logic             u_wr_da_en;
    logic             u_rd_da_en;
    logic [ADR_W-1:0] u_wadr;
    logic [ADR_W-1:0] u_radr;
    logic [DAT_W-1:0] u_wr_da;
    logic [DAT_W-1:0] u_rd_da;
    logic             busy;
    logic             err;
    logic             err_clr;

    modport master (
        input  cap_req, cap_adr, cap_da, rd_req, rd_adr,
        input  u_wack, u_rack, u_wr_da_en, u_rd_da_en, u_rd_da,
        input  err_clr,
        output cap_done, rd_done, rd_da,
        output u_wreq, u_rreq, u_wadr, u_radr, u_wr_da,
        output busy, err
    );

    modport slave (
        output cap_req, cap_adr, cap_da, rd_req, rd_adr,
        output u_wack, u_rack, u_wr_da_en, u_rd_da_en, u_rd_da,
        output err_clr,
        input  cap_done, rd_done, rd_da,
        input  u_wreq, u_rreq, u_wadr, u_radr, u_wr_da,
        input  busy, err
    );

endinterface

// File: rtl/arb_watchdog.sv
// Transaction watchdog: counts cycles spent in one state, flags expiry.
// Ports: clk, reset, clr (restart), en (count), expire (limit reached).
module arb_watchdog
    import sdram_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = wd_width(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    // Counter holds the cycle index within the state, so expiry
    // fires in the TIMEOUT_CYC-th cycle spent there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && (cnt == LAST);

endmodule

// File: rtl/sdram_port_arb.sv
// Shares the SDRAM controller user port between capture writes and readout.
// Ports: clk, reset, bus (requester + controller handshakes, busy/err/err_clr).
module sdram_port_arb
    import sdram_arb_pkg::*;
#(
    parameter int RD_STARVE_MAX = 4,
    parameter int TIMEOUT_CYC   = 255
) (
    input logic             clk,
    input logic             reset,
    sdram_port_arb_if.master bus
);

    localparam int SW = $clog2(RD_STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(RD_STARVE_MAX);

    state_t        state_q;
    state_t        state_d;
    logic          wr_gnt;
    logic          rd_gnt;
    logic          xfer;
    logic          expire;
    logic          wd_clr;
    logic          wr_seen;
    logic          wr_side;
    logic          to_done;
    logic [SW-1:0] starve_cnt;

    assign xfer    = state_q inside {WR_REQ, WR_DATA, RD_REQ, RD_DATA};
    assign wr_side = state_q inside {WR_REQ, WR_DATA};
    assign to_done = (state_d == DONE) && (state_q != DONE);
    assign wd_clr  = (state_d != state_q);

    // Writes win unless the reader has waited out its quota.
    assign wr_gnt = (state_q == IDLE) && bus.cap_req
                  && !(bus.rd_req && starve_cnt == SMAX);
    assign rd_gnt = (state_q == IDLE) && bus.rd_req && !wr_gnt;

    arb_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wd (
        .clk   (clk),
        .reset (reset),
        .clr   (wd_clr),
        .en    (xfer),
        .expire(expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wr_gnt) begin
                    state_d = WR_REQ;
                end else if (rd_gnt) begin
                    state_d = RD_REQ;
                end
            end
            WR_REQ:  if (bus.u_wack) state_d = WR_DATA;
            // Finish on the first low cycle after the enable was seen high.
            WR_DATA: if (wr_seen && !bus.u_wr_da_en) state_d = DONE;
            RD_REQ:  if (bus.u_rack) state_d = RD_DATA;
            RD_DATA: if (bus.u_rd_da_en) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (xfer && expire) begin
            state_d = DONE;
        end
    end

    // Outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.u_wreq   <= 1'b0;
            bus.u_rreq   <= 1'b0;
            bus.u_wadr   <= '0;
            bus.u_radr   <= '0;
            bus.u_wr_da  <= '0;
            bus.rd_da    <= '0;
            bus.cap_done <= 1'b0;
            bus.rd_done  <= 1'b0;
            bus.busy     <= 1'b0;
            bus.err      <= 1'b0;
            wr_seen      <= 1'b0;
            starve_cnt   <= '0;
        end else begin
            bus.u_wreq   <= (state_d == WR_REQ);
            bus.u_rreq   <= (state_d == RD_REQ);
            bus.busy     <= (state_d != IDLE);
            bus.cap_done <= to_done && wr_side;
            bus.rd_done  <= to_done && !wr_side;

            if (wr_gnt) begin
                bus.u_wadr  <= bus.cap_adr;
                bus.u_wr_da <= bus.cap_da;
            end
            if (rd_gnt) begin
                bus.u_radr <= bus.rd_adr;
            end
            // An aborted read returns zero rather than stale data.
            if (to_done && !wr_side) begin
                bus.rd_da <= expire ? '0 : bus.u_rd_da;
            end

            if (state_q != WR_DATA) begin
                wr_seen <= 1'b0;
            end else if (bus.u_wr_da_en) begin
                wr_seen <= 1'b1;
            end

            if (bus.err_clr) begin
                bus.err <= 1'b0;
            end else if (xfer && expire) begin
                bus.err <= 1'b1;
            end

            if (rd_gnt) begin
                starve_cnt <= '0;
            end else if (wr_gnt && bus.rd_req) begin
                if (starve_cnt != SMAX) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else if (state_q == IDLE && !bus.rd_req) begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Self-checking bench for sdram_port_arb with a small controller model.
// Expected write/read results are queued at request time and popped on output.
module tb_sdram_port_arb;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sdram_port_arb_if #(.ADR_W(20), .DAT_W(16)) bus ();

    sdram_port_arb #(
        .RD_STARVE_MAX(4),
        .TIMEOUT_CYC  (255)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [35:0] wr_q[$];
    logic [19:0] radr_q[$];
    logic [15:0] rdat_q[$];
    int          rd_at_wr[$];

    bit never_ack    = 1'b0;
    int wr_gnt_cnt   = 0;
    int cap_done_cyc = 0;
    int rd_done_cyc  = 0;
    int overlap      = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [19:0] a);
        return (a == 20'hFFFFF) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
    endfunction

    // Controller model: write ack two cycles after u_wreq is seen,
    // then a one-cycle u_wr_da_en; read ack in the u_rreq rise cycle.
    initial begin
        int wph = 0;
        int wcnt = 0;
        int rph = 0;
        logic [35:0] e;
        logic [19:0] ra;
        bus.u_wack = 0; bus.u_rack = 0;
        bus.u_wr_da_en = 0; bus.u_rd_da_en = 0; bus.u_rd_da = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                wph = 0; rph = 0;
                bus.u_wack = 0; bus.u_rack = 0;
                bus.u_wr_da_en = 0; bus.u_rd_da_en = 0; bus.u_rd_da = '0;
            end else begin
                case (wph)
                    0: if (bus.u_wreq) begin wcnt = 0; wph = 1; end
                    1: begin
                        if (!bus.u_wreq) begin
                            wph = 0;
                        end else if (!never_ack) begin
                            wcnt++;
                            if (wcnt == 2) begin
                                chk("wr_expected", wr_q.size() > 0, 1);
                                if (wr_q.size() > 0) begin
                                    e = wr_q.pop_front();
                                    chk("u_wadr", bus.u_wadr, e[35:16]);
                                    chk("u_wr_da", bus.u_wr_da, e[15:0]);
                                end
                                bus.u_wack = 1; wph = 2;
                            end
                        end
                    end
                    2: begin bus.u_wack = 0; wph = 3; end
                    3: begin bus.u_wr_da_en = 1; wph = 4; end
                    default: begin bus.u_wr_da_en = 0; wph = 0; end
                endcase
                case (rph)
                    0: if (bus.u_rreq && !never_ack) begin
                        chk("rd_expected", radr_q.size() > 0, 1);
                        ra = (radr_q.size() > 0) ? radr_q.pop_front() : '0;
                        chk("u_radr", bus.u_radr, ra);
                        bus.u_rack = 1; rph = 1;
                    end
                    1: begin bus.u_rack = 0; rph = 2; end
                    2: begin
                        bus.u_rd_da_en = 1; bus.u_rd_da = mem_rd(ra); rph = 3;
                    end
                    default: begin
                        bus.u_rd_da_en = 0; bus.u_rd_da = '0; rph = 0;
                    end
                endcase
            end
        end
    end

    // Output monitor.
    initial begin
        logic wprev = 0;
        logic rprev = 0;
        forever begin
            @(negedge clk);
            if (bus.cap_done) cap_done_cyc++;
            if (bus.rd_done) begin
                rd_done_cyc++;
                chk("rd_done_expected", rdat_q.size() > 0, 1);
                if (rdat_q.size() > 0) chk("rd_da", bus.rd_da, rdat_q.pop_front());
            end
            if (bus.u_wreq && !wprev) wr_gnt_cnt++;
            if (bus.u_rreq && !rprev) rd_at_wr.push_back(wr_gnt_cnt);
            if (bus.u_wreq && bus.u_rreq) overlap++;
            wprev = bus.u_wreq;
            rprev = bus.u_rreq;
        end
    end

    task automatic wait_done(input bit is_rd, input string tag);
        int i;
        for (i = 0; i < 600; i++) begin
            @(negedge clk);
            if (is_rd ? bus.rd_done : bus.cap_done) break;
        end
        chk(tag, i < 600, 1);
    endtask

    task automatic req_writes(input int n, input logic [19:0] a0);
        for (int k = 0; k < n; k++) begin
            bus.cap_adr = a0 + 20'(k);
            bus.cap_da  = 16'hC000 + 16'(k);
            wr_q.push_back({bus.cap_adr, bus.cap_da});
            bus.cap_req = 1;
            wait_done(0, "wr_done_seen");
        end
        bus.cap_req = 0;
    endtask

    task automatic req_reads(input int n, input logic [19:0] a0);
        for (int k = 0; k < n; k++) begin
            bus.rd_adr = a0 + 20'(k);
            radr_q.push_back(bus.rd_adr);
            rdat_q.push_back(mem_rd(bus.rd_adr));
            bus.rd_req = 1;
            wait_done(1, "rd_done_seen");
        end
        bus.rd_req = 0;
    endtask

    task automatic tmo_write(input bit clr_at_expire, output int hi);
        bus.cap_adr = 20'h00777;
        bus.cap_da  = 16'h7777;
        bus.cap_req = 1;
        hi = 0;
        for (int i = 0; i < 20 && !bus.u_wreq; i++) @(negedge clk);
        while (bus.u_wreq && hi < 400) begin
            hi++;
            if (clr_at_expire && hi == 255) bus.err_clr = 1;
            @(negedge clk);
        end
        chk("tmo_cap_done", bus.cap_done, 1);
        bus.err_clr = 0;
        bus.cap_req = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1 want 0");
        $fatal(1, "bench stalled");
    end

    initial begin
        int d0;
        int base;
        int hi;
        reset = 1;
        bus.cap_req = 0; bus.cap_adr = '0; bus.cap_da = '0;
        bus.rd_req = 0; bus.rd_adr = '0; bus.err_clr = 0;
        @(negedge clk);
        chk("rst_any", |{bus.u_wreq, bus.u_rreq, bus.u_wadr, bus.u_radr,
                         bus.u_wr_da, bus.rd_da, bus.cap_done, bus.rd_done}, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);

        // Single write with grant-latency check.
        d0 = cap_done_cyc;
        bus.cap_adr = 20'h00010;
        bus.cap_da  = 16'h1234;
        wr_q.push_back({20'h00010, 16'h1234});
        bus.cap_req = 1;
        @(negedge clk);
        chk("t1_wreq_lat", bus.u_wreq, 1);
        chk("t1_busy", bus.busy, 1);
        wait_done(0, "t1_done_seen");
        bus.cap_req = 0;
        repeat (3) @(negedge clk);
        chk("t1_done_cnt", cap_done_cyc - d0, 1);
        chk("t1_err", bus.err, 0);

        // Single read at top address, then data hold.
        d0 = rd_done_cyc;
        req_reads(1, 20'hFFFFF);
        repeat (4) @(negedge clk);
        chk("t2_hold", bus.rd_da, 16'hBEEF);
        chk("t2_done_cnt", rd_done_cyc - d0, 1);

        // Simultaneous requests: write first.
        base = wr_gnt_cnt;
        rd_at_wr.delete();
        fork
            req_writes(1, 20'h00020);
            req_reads(1, 20'h00030);
        join
        chk("t3_rd_gnts", rd_at_wr.size(), 1);
        chk("t3_order", rd_at_wr[0] - base, 1);

        // Starvation guard: read after 4 writes, counter restarts.
        base = wr_gnt_cnt;
        rd_at_wr.delete();
        fork
            req_writes(9, 20'h00100);
            req_reads(2, 20'h00200);
        join
        chk("t4_rd_gnts", rd_at_wr.size(), 2);
        chk("t4_first_rd", rd_at_wr[0] - base, 4);
        chk("t4_second_rd", rd_at_wr[1] - base, 8);
        chk("t4_wr_gnts", wr_gnt_cnt - base, 9);

        // Watchdog on a write that is never acknowledged.
        never_ack = 1;
        repeat (2) @(negedge clk);
        d0 = cap_done_cyc;
        tmo_write(0, hi);
        chk("t5_wreq_cycles", hi, 255);
        chk("t5_err_set", bus.err, 1);
        repeat (3) @(negedge clk);
        chk("t5_done_cnt", cap_done_cyc - d0, 1);
        bus.err_clr = 1;
        @(negedge clk);
        bus.err_clr = 0;
        chk("t5_err_clr", bus.err, 0);
        repeat (2) @(negedge clk);
        tmo_write(1, hi);
        chk("t5_clr_prio", bus.err, 0);
        repeat (2) @(negedge clk);
        rdat_q.push_back(16'h0000);
        bus.rd_adr = 20'h00300;
        bus.rd_req = 1;
        wait_done(1, "t5_rd_done_seen");
        bus.rd_req = 0;
        chk("t5_rd_err", bus.err, 1);
        never_ack = 0;
        bus.err_clr = 1;
        @(negedge clk);
        bus.err_clr = 0;
        @(negedge clk);

        // Asynchronous reset during WR_DATA, then a clean write.
        d0 = cap_done_cyc;
        bus.cap_adr = 20'h00400;
        bus.cap_da  = 16'h5555;
        wr_q.push_back({20'h00400, 16'h5555});
        bus.cap_req = 1;
        for (int i = 0; i < 40 && !bus.u_wr_da_en; i++) @(negedge clk);
        chk("t6_busy", bus.busy, 1);
        #2;
        reset = 1;
        #1;
        chk("t6_async_out", |{bus.u_wreq, bus.u_rreq, bus.u_wadr, bus.u_radr,
                              bus.u_wr_da, bus.rd_da, bus.cap_done,
                              bus.rd_done, bus.err}, 0);
        chk("t6_async_busy", bus.busy, 0);
        bus.cap_req = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        req_writes(1, 20'h00500);
        repeat (3) @(negedge clk);
        chk("t6_done_cnt", cap_done_cyc - d0, 1);

        chk("no_overlap", overlap, 0);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("radr_q_empty", radr_q.size(), 0);
        chk("rdat_q_empty", rdat_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_port_arb.md
# sdram_port_arb

Single-port SDRAM user-side arbiter sharing the SDRAM controller's user write/read port between the HSDC capture path (write requester) and the SPI readout path (read requester). It issues one word transaction at a time to the controller's u_wreq/u_wack/u_wr_da_en and u_rreq/u_rack/u_rd_da_en handshakes. Capture writes have priority, with a starvation guard for readout. A watchdog recovers from a controller that never completes a transaction.

## Interface
- ADR_W, 20, SDRAM word address width (matches u_wadr/u_radr)
- DAT_W, 16, SDRAM data width
- RD_STARVE_MAX, 4, consecutive write grants allowed while rd_req pending before a forced read grant (≥1)
- TIMEOUT_CYC, 255, cycles allowed in any non-idle transaction state before abort (≥8)
- clk  in  1  system clock, shared with SDRAM controller
- reset  in  1  asynchronous, active-high reset
- cap_req  in  1  capture write request; level, held until cap_done
- cap_adr  in  ADR_W  write address, sampled at grant
- cap_da  in  DAT_W  write data, sampled at grant
- cap_done  out  1  one-cycle pulse: write finished (or aborted)
- rd_req  in  1  readout request; level, held until rd_done
- rd_adr  in  ADR_W  read address, sampled at grant
- rd_done  out  1  one-cycle pulse: rd_da valid
- rd_da  out  DAT_W  read data, held until next rd_done
- u_wreq / u_rreq  out  1  to controller
- u_wack / u_rack  in  1  from controller
- u_wr_da_en / u_rd_da_en  in  1  from controller
- u_wadr / u_radr  out  ADR_W  to controller
- u_wr_da  out  DAT_W  to controller
- u_rd_da  in  DAT_W  from controller
- busy  out  1  state ≠ IDLE
- err  out  1  sticky timeout flag
- err_clr  in  1  clears err (takes priority over a simultaneous set)

## Operation
- States: IDLE, WR_REQ, WR_DATA, RD_REQ, RD_DATA, DONE.
- IDLE: cap_req granted unless rd_req && starve_cnt == RD_STARVE_MAX, in which case rd_req is granted. Only one requester → grant it. On grant, latch adr/da into u_wadr/u_wr_da or u_radr.
- WR_REQ: u_wreq=1 until u_wack sampled high; then u_wreq=0, → WR_DATA.
- WR_DATA: wait for u_wr_da_en rising then falling; on the falling edge (first cycle low after high) → DONE, flag write.
- RD_REQ: u_rreq=1 until u_rack sampled high; then u_rreq=0, → RD_DATA.
- RD_DATA: on first cycle u_rd_da_en=1, register u_rd_da into rd_da, → DONE, flag read.
- DONE: pulse cap_done or rd_done for exactly one cycle. No grant in this cycle, so requesters update req/adr/da on the done edge. → IDLE.
- starve_cnt: +1 (saturating at RD_STARVE_MAX) on each write grant while rd_req=1; cleared on read grant or when rd_req=0 in IDLE.
- Watchdog: counter cleared on entry to any non-IDLE, non-DONE state. On reaching TIMEOUT_CYC: drop u_wreq/u_rreq, set err, → DONE. DONE still pulses the owner's done so requesters never hang. On a read abort, rd_da=0.
- Reset mid-transaction: in-flight transaction abandoned without notification (controller shares reset); state IDLE.

## Timing
- Reset values: all outputs 0 (u_wreq, u_rreq, u_wadr, u_radr, u_wr_da, rd_da, cap_done, rd_done, busy, err); starve_cnt=0.
- All outputs registered.
- Grant latency: req high at edge N → u_wreq/u_rreq high after edge N+1.
- u_wreq falls one cycle after u_wack is sampled.
- Read: u_rd_da_en sampled at edge M → rd_da updated and rd_done high after edge M+1.
- Write: u_wr_da_en sampled low (after high) at edge M → cap_done high after edge M+1.
- Minimum back-to-back spacing: done cycle plus one IDLE cycle between transactions.
- u_wack asserted in the same cycle as u_wreq rises is valid.
- A u_wr_da_en pulse of a single cycle is valid.

## Structure
- Package sdram_arb_pkg: state enum (IDLE..DONE), ADR_W/DAT_W defaults, watchdog width function clog2(TIMEOUT_CYC+1).
- One sub-module, arb_watchdog: clear/enable inputs, expire output, parameter TIMEOUT_CYC.

## Test plan
- cap_req, adr 0x00010, da 0x1234; model acks after 2 cycles with 1-cycle u_wr_da_en -> u_wreq high one cycle after req; u_wadr=0x00010, u_wr_da=0x1234; exactly one cap_done; err=0.
- rd_req, adr 0xFFFFF; model returns 0xBEEF -> u_radr=0xFFFFF; rd_done once with rd_da=0xBEEF; rd_da holds afterward.
- cap_req and rd_req rise in the same cycle -> write completes first, then read; no overlapping u_wreq/u_rreq.
- cap_req held continuously (new adr each done), rd_req held, RD_STARVE_MAX=4 -> read granted right after the 4th write's DONE; starve_cnt clears after the read grant.
- Model never asserts u_wack -> u_wreq drops after 255 cycles; err=1; cap_done pulses once. Then err_clr=1 -> err=0. Simultaneous expire and err_clr -> err=0.
- reset asserted during WR_DATA -> all outputs 0 asynchronously; next cap_req after release starts a clean transaction.
